time_update_arbiter: RTL and testbench
======================================

// Module: time_update_arbiter
// PURPOSE
//   Merges the three increment sources of the time counters into one-cycle,
//   mutually exclusive increment pulses, one source per cycle:
//     - the 1 Hz seconds tick
//     - the set-minutes button
//     - the set-hours button
//   Replaces the plain OR merge of tick and button strobes. Adds edge
//   detection, press-and-hold auto-repeat, and fixed-priority arbitration.
//   Sits between the debounced button / prescaler outputs and the sec/min/hr
//   counter chain.
// PARAMETERS
//   HOLD_CYCLES    default 50_000_000  cycles a button must stay high before auto-repeat starts
//   REPEAT_CYCLES  default 12_500_000  cycles between auto-repeat strobes while held
//   (both >= 2; internal counter width = $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1))
// PORTS
//   clk        in   1  system clock; all logic rising-edge
//   rst        in   1  synchronous, active-high reset
//   tick_1hz   in   1  one-cycle pulse from prescaler, 1 per second
//   set_mode   in   1  1 = time-set mode, 0 = run mode (level)
//   btn_min    in   1  debounced set-minutes button (level, active-high)
//   btn_hr     in   1  debounced set-hours button (level, active-high)
//   sec_inc    out  1  one-cycle pulse: increment seconds counter
//   min_inc    out  1  one-cycle pulse: increment minutes counter
//   hr_inc     out  1  one-cycle pulse: increment hours counter
//   req_drop   out  1  sticky: a request arrived while same source already pending
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     - all outputs 0, all pending flags 0, repeat FSMs to IDLE, hold/repeat counters 0
//     - button edge-detect registers take the current btn level, so a button
//       held through reset produces no strobe
//   Request generation:
//     - tick request: tick_1hz=1 while set_mode=0; ticks during set_mode=1
//       are discarded (seconds frozen)
//     - button request: strobe from that button's repeat FSM, only while
//       set_mode=1; in run mode the button FSMs are forced to IDLE
//   Repeat FSM (one per button), on each clk:
//     - IDLE:   btn 0->1 edge  -> strobe, clear cnt, go HOLD
//     - HOLD:   btn=0 -> IDLE;
//               else cnt++, and when cnt==HOLD_CYCLES-1 -> strobe, clear cnt, go REPEAT
//     - REPEAT: btn=0 -> IDLE;
//               else cnt++, and when cnt==REPEAT_CYCLES-1 -> strobe, clear cnt
//     - set_mode falling while in HOLD/REPEAT -> IDLE, no strobe
//   Pending/arbitration:
//     - each source has a pending flag, set by its request
//     - one grant per cycle, fixed priority: tick > min > hr
//     - grant registered: request in cycle N -> pulse in cycle N+1 if highest
//       pending, else later
//     - granted flag clears the same edge its pulse is asserted
//     - request arriving while its own flag is still pending (and not being
//       granted that cycle) is merged; req_drop set to 1, stays 1 until rst
//     - request in same cycle its pending flag is granted re-arms the flag
//       (not a drop)
//   Outputs:
//     - sec_inc, min_inc, hr_inc are registered
//     - never more than one high in any cycle; each high for exactly 1 cycle
//       per grant
//   Simultaneous events:
//     - tick and both button strobes in same cycle -> sec, min, hr pulses in
//       cycles N+1, N+2, N+3
//     - rst mid-operation wins over everything; pending requests are lost
// TESTING (bench overrides HOLD_CYCLES=4, REPEAT_CYCLES=3)
//   1. rst 2 cycles, set_mode=0, tick_1hz pulse at cycle 10
//      -> sec_inc=1 at cycle 11 only; min_inc=hr_inc=0; req_drop=0
//   2. set_mode=1, btn_min rises at cycle 20, held to cycle 40
//      -> min_inc at 21 (edge), 25 (hold), then every 3 cycles: 28, 31, ...;
//         none after release
//   3. set_mode=0, tick pulse + btn_hr rise in same cycle
//      -> sec_inc next cycle; hr_inc never (run mode)
//   4. set_mode=1, tick_1hz, btn_min, btn_hr strobes coincide in cycle 50
//      -> no sec_inc (frozen); min_inc at 51, hr_inc at 52; never two outputs
//         high together
//   5. btn_min high at rst deassertion -> no min_inc until release and
//      re-press; re-press at cycle 30 -> min_inc at 31
//   6. btn_hr held in REPEAT; rst pulsed at cycle 60
//      -> all outputs 0 at 61; FSM IDLE; no strobe until new rising edge

Source files
------------

// File: rtl/time_update_arbiter.sv
// time_update_arbiter
// Merges the 1 Hz seconds tick and the set-minutes / set-hours buttons into
// one-cycle, mutually exclusive increment pulses. Each button has its own
// press-and-hold auto-repeat FSM. Requests are latched into pending flags
// and granted one per cycle with fixed priority tick > min > hr.
//
// Handshake: there is no back-pressure. A request is a single-cycle strobe
// that sets the pending flag of its source. The granted flag clears on the
// same edge that its registered pulse goes high. A request that finds its
// own flag already pending, and not being granted, is merged and raises the
// sticky req_drop flag.
module time_update_arbiter #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1hz,
  input  logic set_mode,
  input  logic btn_min,
  input  logic btn_hr,
  output logic sec_inc,
  output logic min_inc,
  output logic hr_inc,
  output logic req_drop
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Button index 0 = minutes, 1 = hours.
  logic [1:0]    btn;
  logic [1:0]    btn_q;
  logic [1:0]    strobe;
  rep_state_t    state_q [2];
  rep_state_t    state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];

  // Source index 0 = tick, 1 = min, 2 = hr.
  logic [2:0] req;
  logic [2:0] eff;
  logic [2:0] gnt;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic       drop_ev;

  assign btn = {btn_hr, btn_min};

  // Repeat FSMs: next state, hold/repeat counters and strobes.
  always_comb begin
    strobe = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!set_mode) begin
        // Run mode (including a set_mode fall mid-hold) parks the FSM silently.
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (btn[i] && !btn_q[i]) begin
              strobe[i]  = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = HOLD;
            end
          end
          HOLD: begin
            if (!btn[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == HOLD_LAST) begin
              strobe[i]  = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = REPEAT;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          REPEAT: begin
            if (!btn[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == REPEAT_LAST) begin
              strobe[i] = 1'b1;
              cnt_d[i]  = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Requests, fixed-priority grant and pending-flag update.
  always_comb begin
    req     = {strobe[1], strobe[0], tick_1hz & ~set_mode};
    eff     = pend_q | req;
    gnt     = 3'b000;
    if (eff[0])      gnt = 3'b001;
    else if (eff[1]) gnt = 3'b010;
    else if (eff[2]) gnt = 3'b100;
    for (int i = 0; i < 3; i++) begin
      // A request landing on the cycle its pending flag is granted re-arms it.
      pend_d[i] = pend_q[i] ? (~gnt[i] | req[i]) : (req[i] & ~gnt[i]);
    end
    drop_ev = |(req & pend_q & ~gnt);
  end

  // State register: FSMs, counters, edge detect, pending flags, outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      btn_q    <= btn;
      pend_q   <= 3'b000;
      sec_inc  <= 1'b0;
      min_inc  <= 1'b0;
      hr_inc   <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_q    <= btn;
      pend_q   <= pend_d;
      sec_inc  <= gnt[0];
      min_inc  <= gnt[1];
      hr_inc   <= gnt[2];
      req_drop <= req_drop | drop_ev;
    end
  end

endmodule

// File: tb/tb_time_update_arbiter.sv
// Directed bench for time_update_arbiter with HOLD_CYCLES=4, REPEAT_CYCLES=3.
// Inputs are changed 1 ns after a rising edge; outputs are checked 1 ns after
// the following rising edge, so each step() covers one clock cycle.
module tb_time_update_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic tick_1hz;
  logic set_mode;
  logic btn_min;
  logic btn_hr;
  logic sec_inc;
  logic min_inc;
  logic hr_inc;
  logic req_drop;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_drop = 1'b0;

  time_update_arbiter #(
    .HOLD_CYCLES  (4),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1hz(tick_1hz),
    .set_mode(set_mode),
    .btn_min (btn_min),
    .btn_hr  (btn_hr),
    .sec_inc (sec_inc),
    .min_inc (min_inc),
    .hr_inc  (hr_inc),
    .req_drop(req_drop)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got sec/min/hr/drop=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and compare {sec_inc,min_inc,hr_inc} and req_drop.
  task automatic step(input string tag, input logic [2:0] exp_out);
    @(posedge clk);
    #1;
    check(tag, {sec_inc, min_inc, hr_inc, req_drop}, {exp_out, exp_drop});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_drop = 1'b0;
    for (int i = 0; i < cycles; i++) step("reset", 3'b000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; set_mode = 1'b0; btn_min = 1'b0; btn_hr = 1'b0;
    #1;

    // 1. single tick in run mode -> one sec_inc
    do_reset(2);
    for (int i = 0; i < 3; i++) step("idle", 3'b000);
    tick_1hz = 1'b1;
    step("tick_sec", 3'b100);
    tick_1hz = 1'b0;
    for (int i = 0; i < 3; i++) step("tick_after", 3'b000);

    // 2. press-and-hold: pulses at edge, +4, then every 3
    set_mode = 1'b1;
    step("setmode_idle", 3'b000);
    btn_min = 1'b1;
    for (int k = 0; k < 12; k++)
      step("min_repeat", (k == 0 || k == 4 || k == 7 || k == 10) ? 3'b010 : 3'b000);
    btn_min = 1'b0;
    for (int i = 0; i < 5; i++) step("min_release", 3'b000);

    // 3. run mode: tick and hr press together -> only sec_inc
    set_mode = 1'b0;
    tick_1hz = 1'b1;
    btn_hr   = 1'b1;
    step("run_tick_hr", 3'b100);
    tick_1hz = 1'b0;
    for (int i = 0; i < 3; i++) step("run_hr_held", 3'b000);
    set_mode = 1'b1;
    for (int i = 0; i < 6; i++) step("held_into_set", 3'b000);
    btn_hr = 1'b0;
    step("hr_release", 3'b000);

    // 4. set mode: tick + min + hr coincide -> min then hr, tick frozen
    tick_1hz = 1'b1;
    btn_min  = 1'b1;
    btn_hr   = 1'b1;
    step("coincide_min", 3'b010);
    tick_1hz = 1'b0;
    btn_min  = 1'b0;
    btn_hr   = 1'b0;
    step("coincide_hr", 3'b001);
    for (int i = 0; i < 3; i++) step("coincide_after", 3'b000);

    // 7. merged request sets sticky req_drop
    btn_min = 1'b1; btn_hr = 1'b1;
    step("drop_a", 3'b010);
    set_mode = 1'b0; tick_1hz = 1'b1; btn_min = 1'b0; btn_hr = 1'b0;
    step("drop_b_tick", 3'b100);
    set_mode = 1'b1; tick_1hz = 1'b0; btn_min = 1'b1; btn_hr = 1'b1;
    exp_drop = 1'b1;
    step("drop_c_merge", 3'b010);
    btn_min = 1'b0; btn_hr = 1'b0;
    step("drop_d_hr", 3'b001);
    for (int i = 0; i < 3; i++) step("drop_sticky", 3'b000);

    // 5. button held through reset -> nothing until re-press
    btn_min = 1'b1;
    do_reset(2);
    for (int i = 0; i < 6; i++) step("held_thru_rst", 3'b000);
    btn_min = 1'b0;
    step("rst_release", 3'b000);
    btn_min = 1'b1;
    step("repress", 3'b010);
    btn_min = 1'b0;
    for (int i = 0; i < 2; i++) step("repress_after", 3'b000);

    // 6. reset while hr is auto-repeating
    btn_hr = 1'b1;
    for (int k = 0; k < 9; k++)
      step("hr_repeat", (k == 0 || k == 4 || k == 7) ? 3'b001 : 3'b000);
    do_reset(1);
    for (int i = 0; i < 6; i++) step("hr_after_rst", 3'b000);
    btn_hr = 1'b0;
    step("hr_rel2", 3'b000);
    btn_hr = 1'b1;
    step("hr_repress", 3'b001);
    btn_hr = 1'b0;
    for (int i = 0; i < 2; i++) step("final_idle", 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Independent mutual-exclusion monitor on the falling edge.
  always @(negedge clk) begin
    if (!rst && (int'(sec_inc) + int'(min_inc) + int'(hr_inc)) > 1) begin
      n_checks++;
      n_errors++;
      $display("FAIL onehot: sec/min/hr=%b%b%b expected at most one high", sec_inc, min_inc, hr_inc);
    end
  end

endmodule
